// File: rtl/nios_qsys_irq_ctrl_if.sv
// Avalon-MM slave bus of the interrupt aggregator: word address, select, write strobe and
// registered read data.
interface nios_qsys_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_qsys_irq_ctrl.sv
// Interrupt aggregator: per-line level/edge mode, enable mask, pending latch, lowest-index
// vector with acknowledge, and a post-acknowledge holdoff counter gating the CPU irq.
module nios_qsys_irq_ctrl #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios_qsys_irq_ctrl_if.slave  bus,
    input  logic [NUM_IRQ-1:0]   irq_in,
    output logic                 irq
);
    typedef logic [NUM_IRQ-1:0] vec_t;

    vec_t        irq_s, irq_d, edge_lat, edge_lat_d, enable, mode;
    vec_t        rise, pend, active, ack_mask;
    logic [15:0] holdoff, holdoff_cnt, rd_d;
    logic [3:0]  idx;
    logic        any_active, wr, ack;

    function automatic logic [15:0] ext(vec_t v);
        logic [15:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    assign wr         = bus.chipselect && !bus.write_n;
    assign rise       = irq_s & ~irq_d;
    assign pend       = (mode & edge_lat) | (~mode & irq_s);
    assign active     = pend & enable;
    assign any_active = |active;
    assign ack        = wr && (bus.address == 3'd4) && any_active;

    // Lowest index wins, so scan downwards and let the last hit stick.
    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) idx = 4'(i);
        end
    end

    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_mask[i] = ack && (idx == 4'(i));
        end
    end

    // Clears first, then a new rising edge re-sets; a mode switch to level always wins.
    always_comb begin
        edge_lat_d = edge_lat;
        if (wr && bus.address == 3'd0) edge_lat_d = edge_lat_d & ~bus.writedata[NUM_IRQ-1:0];
        edge_lat_d = (edge_lat_d & ~ack_mask) | (rise & mode);
        if (wr && bus.address == 3'd2) edge_lat_d = edge_lat_d & bus.writedata[NUM_IRQ-1:0];
    end

    always_comb begin
        rd_d = '0;
        case (bus.address)
            3'd0:    rd_d = ext(pend);
            3'd1:    rd_d = ext(enable);
            3'd2:    rd_d = ext(mode);
            3'd3:    rd_d = ext(irq_s);
            3'd4:    rd_d = {any_active, 11'b0, idx};
            3'd5:    rd_d = holdoff;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_s        <= '0;
            irq_d        <= '0;
            edge_lat     <= '0;
            enable       <= '0;
            mode         <= '0;
            holdoff      <= '0;
            holdoff_cnt  <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            irq_s        <= irq_in;
            irq_d        <= irq_s;
            edge_lat     <= edge_lat_d;
            bus.readdata <= rd_d;
            irq          <= any_active && (holdoff_cnt == 16'd0);
            if (wr && bus.address == 3'd1) enable  <= bus.writedata[NUM_IRQ-1:0];
            if (wr && bus.address == 3'd2) mode    <= bus.writedata[NUM_IRQ-1:0];
            if (wr && bus.address == 3'd5) holdoff <= bus.writedata;
            if (wr && (bus.address == 3'd0 || bus.address == 3'd4)) begin
                holdoff_cnt <= holdoff;
            end else if (holdoff_cnt != 16'd0) begin
                holdoff_cnt <= holdoff_cnt - 16'd1;
            end
        end
    end
endmodule
